// File: rtl/bid_arb_pkg.sv
// rtl/bid_arb_pkg.sv - shared types and default constants for the bid/credit arbiter
package bid_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int BID_W_DEF         = 8;
    localparam int CRED_W_DEF        = 10;
    localparam int CRED_INIT_DEF     = 25;
    localparam int REFILL_AMT_DEF    = 25;
    localparam int REFILL_PERIOD_DEF = 16;
    localparam int CRED_MAX_DEF      = 150;
    localparam int MAX_HOLD_DEF      = 8;

    localparam int              AGE_W   = 4;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

endpackage

// File: rtl/bid_arb_pick.sv
// rtl/bid_arb_pick.sv - combinational winner select: highest bid, round-robin tie-break,
// aged masters outrank every bid and tie among themselves.
module bid_arb_pick
    import bid_arb_pkg::*;
#(
    parameter int N_MST = 4,
    parameter int BID_W = BID_W_DEF
) (
    input  logic [N_MST-1:0]         elig,
    input  logic [N_MST-1:0]         aged,
    input  logic [N_MST*BID_W-1:0]   bid,
    input  logic [$clog2(N_MST)-1:0] rr_ptr,
    output logic [$clog2(N_MST)-1:0] win_id,
    output logic                     win_vld
);

    localparam int IDW = $clog2(N_MST);

    // Scan in round-robin order from rr_ptr; strict '>' keeps the earliest on ties.
    always_comb begin
        logic [BID_W:0] key;
        logic [BID_W:0] best_key;
        int             idx;
        win_id   = '0;
        win_vld  = 1'b0;
        best_key = '0;
        key      = '0;
        idx      = 0;
        for (int k = 0; k < N_MST; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_MST) begin
                idx = idx - N_MST;
            end
            key = aged[idx] ? {1'b1, {BID_W{1'b0}}} : {1'b0, bid[idx*BID_W +: BID_W]};
            if (elig[idx] && (!win_vld || key > best_key)) begin
                win_vld  = 1'b1;
                best_key = key;
                win_id   = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/bid_credit_arbiter.sv
// rtl/bid_credit_arbiter.sv - credit/bid bus arbiter: FSM, credit ledger, refill and hold timers.
// Optional age-based starvation override: define BID_ARB_AGING_EN.
module bid_credit_arbiter
    import bid_arb_pkg::*;
#(
    parameter int N_MST         = 4,
    parameter int BID_W         = BID_W_DEF,
    parameter int CRED_W        = CRED_W_DEF,
    parameter int CRED_INIT     = CRED_INIT_DEF,
    parameter int REFILL_AMT    = REFILL_AMT_DEF,
    parameter int REFILL_PERIOD = REFILL_PERIOD_DEF,
    parameter int CRED_MAX      = CRED_MAX_DEF,
    parameter int MAX_HOLD      = MAX_HOLD_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_MST-1:0]          req,
    input  logic [N_MST*BID_W-1:0]    bid,
    input  logic [N_MST-1:0]          done,
    output logic [N_MST-1:0]          grant,
    output logic [$clog2(N_MST)-1:0]  grant_id,
    output logic                      grant_vld,
    output logic                      abort,
    output logic [N_MST*CRED_W-1:0]   credit
);

    localparam int IDW    = $clog2(N_MST);
    localparam int CW1    = CRED_W + 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int REF_W  = $clog2(REFILL_PERIOD + 1);

    state_e             state_q, state_d;
    logic [N_MST-1:0]   grant_q, grant_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic               grant_vld_q, grant_vld_d;
    logic               abort_q, abort_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic [CRED_W-1:0]  cred_q [N_MST];
    logic [CRED_W-1:0]  cred_d [N_MST];

    logic [N_MST-1:0]   elig;
    logic [N_MST-1:0]   aged;
    logic [N_MST-1:0]   debit;
    logic               refill_fire;
    logic [IDW-1:0]     win_id;
    logic               win_vld;
    logic               owner_done;
    logic               hold_limit;

    always_comb begin
        for (int i = 0; i < N_MST; i++) begin
            elig[i] = req[i] && (bid[i*BID_W +: BID_W] != '0)
                      && ({1'b0, cred_q[i]} >= CW1'(bid[i*BID_W +: BID_W]));
        end
    end

    bid_arb_pick #(
        .N_MST (N_MST),
        .BID_W (BID_W)
    ) u_pick (
        .elig    (elig),
        .aged    (aged),
        .bid     (bid),
        .rr_ptr  (rr_ptr_q),
        .win_id  (win_id),
        .win_vld (win_vld)
    );

    always_comb begin
        refill_fire = (ref_cnt_q == REF_W'(REFILL_PERIOD - 1));
        ref_cnt_d   = refill_fire ? '0 : ref_cnt_q + REF_W'(1);
    end

    // Debit and refill fold into one widened sum so a coincident pair is never lost.
    always_comb begin
        logic [CW1-1:0] sum;
        sum = '0;
        for (int i = 0; i < N_MST; i++) begin
            sum = {1'b0, cred_q[i]};
            if (debit[i]) begin
                sum = sum - CW1'(bid[i*BID_W +: BID_W]);
            end
            if (refill_fire) begin
                sum = sum + CW1'(REFILL_AMT);
            end
            cred_d[i] = (sum > CW1'(CRED_MAX)) ? CRED_W'(CRED_MAX) : sum[CRED_W-1:0];
        end
    end

    assign owner_done = done[grant_id_q] || !req[grant_id_q];
    assign hold_limit = (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        grant_vld_d = grant_vld_q;
        abort_d     = 1'b0;
        rr_ptr_d    = rr_ptr_q;
        hold_d      = hold_q;
        debit       = '0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d       = GRANT;
                    grant_d       = N_MST'(1) << win_id;
                    grant_id_d    = win_id;
                    grant_vld_d   = 1'b1;
                    rr_ptr_d      = (win_id == IDW'(N_MST - 1)) ? '0 : win_id + IDW'(1);
                    hold_d        = '0;
                    debit[win_id] = 1'b1;
                end
            end
            GRANT: begin
                hold_d = hold_q + HOLD_W'(1);
                // A completion on the last allowed cycle is a normal release, not an abort.
                if (owner_done || hold_limit) begin
                    state_d     = GAP;
                    grant_d     = '0;
                    grant_vld_d = 1'b0;
                    hold_d      = '0;
                    abort_d     = !owner_done;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef BID_ARB_AGING_EN
    logic [AGE_W-1:0] age_q [N_MST];
    logic [AGE_W-1:0] age_d [N_MST];

    always_comb begin
        for (int i = 0; i < N_MST; i++) begin
            aged[i] = (age_q[i] == AGE_MAX);
        end
    end

    always_comb begin
        for (int i = 0; i < N_MST; i++) begin
            if (!req[i] || grant_q[i] || debit[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] != AGE_MAX) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_MST; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_MST; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
`else
    assign aged = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            grant_vld_q <= 1'b0;
            abort_q     <= 1'b0;
            rr_ptr_q    <= '0;
            hold_q      <= '0;
            ref_cnt_q   <= '0;
            for (int i = 0; i < N_MST; i++) begin
                cred_q[i] <= CRED_W'(CRED_INIT);
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            grant_vld_q <= grant_vld_d;
            abort_q     <= abort_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_q      <= hold_d;
            ref_cnt_q   <= ref_cnt_d;
            for (int i = 0; i < N_MST; i++) begin
                cred_q[i] <= cred_d[i];
            end
        end
    end

    assign grant     = grant_q;
    assign grant_id  = grant_id_q;
    assign grant_vld = grant_vld_q;
    assign abort     = abort_q;

    always_comb begin
        for (int i = 0; i < N_MST; i++) begin
            credit[i*CRED_W +: CRED_W] = cred_q[i];
        end
    end

endmodule

// File: tb/tb_bid_credit_arbiter.sv
// tb/tb_bid_credit_arbiter.sv - directed and randomized checks of bid_credit_arbiter against a reference model
module tb_bid_credit_arbiter;

    localparam int N     = 4;
    localparam int BW    = 8;
    localparam int CW    = 10;
    localparam int CINIT = 25;
    localparam int AMT   = 25;
    localparam int PER   = 16;
    localparam int CMAX  = 150;
    localparam int HOLD  = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req;
    logic [N*BW-1:0] bid;
    logic [N-1:0]    done;
    logic [N-1:0]    grant;
    logic [1:0]      grant_id;
    logic            grant_vld;
    logic            abort;
    logic [N*CW-1:0] credit;

    int vectors = 0;
    int miscompares = 0;

    int m_cred [N];
    int bids [N];
    int m_phase;
    int m_owner;
    int m_hold;
    int m_rr;
    int m_edges;
    bit m_abort;

    always #5 clk = ~clk;

    bid_credit_arbiter #(
        .N_MST         (N),
        .BID_W         (BW),
        .CRED_W        (CW),
        .CRED_INIT     (CINIT),
        .REFILL_AMT    (AMT),
        .REFILL_PERIOD (PER),
        .CRED_MAX      (CMAX),
        .MAX_HOLD      (HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .bid       (bid),
        .done      (done),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld),
        .abort     (abort),
        .credit    (credit)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int crd(input int i);
        return int'(credit[i*CW +: CW]);
    endfunction

    task automatic drive_bids();
        for (int i = 0; i < N; i++) begin
            bid[i*BW +: BW] = BW'(bids[i]);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < N; i++) begin
            m_cred[i] = CINIT;
        end
        m_phase = 0;
        m_owner = 0;
        m_hold  = 0;
        m_rr    = 0;
        m_edges = 0;
        m_abort = 1'b0;
    endtask

    task automatic check_outputs();
        logic [N*CW-1:0] ec;
        for (int i = 0; i < N; i++) begin
            ec[i*CW +: CW] = CW'(m_cred[i]);
        end
        chk("grant", 64'(grant), 64'(m_phase == 1 ? (1 << m_owner) : 0));
        chk("grant_vld", 64'(grant_vld), 64'(m_phase == 1));
        if (m_phase == 1) begin
            chk("grant_id", 64'(grant_id), 64'(m_owner));
        end
        chk("abort", 64'(abort), 64'(m_abort));
        chk("credit", 64'(credit), 64'(ec));
    endtask

    // One clock: the model consumes the inputs present before the edge, then outputs are compared.
    task automatic step();
        int  best;
        int  win;
        int  bd;
        int  c;
        bit  fire;
        drive_bids();
        win  = -1;
        best = 0;
        if (m_phase == 0) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && bids[i] != 0 && bids[i] <= m_cred[i] && bids[i] > best) best = bids[i];
            end
            bd = N;
            for (int i = 0; i < N; i++) begin
                if (best > 0 && req[i] && bids[i] == best && bids[i] <= m_cred[i]
                    && ((i - m_rr + N) % N) < bd) begin
                    bd  = (i - m_rr + N) % N;
                    win = i;
                end
            end
        end
        fire = ((m_edges + 1) % PER) == 0;
        for (int i = 0; i < N; i++) begin
            c = m_cred[i] - ((i == win) ? bids[i] : 0) + (fire ? AMT : 0);
            m_cred[i] = (c > CMAX) ? CMAX : c;
        end
        m_abort = 1'b0;
        case (m_phase)
            0: if (win >= 0) begin
                m_phase = 1;
                m_owner = win;
                m_rr    = (win + 1) % N;
                m_hold  = 0;
            end
            1: begin
                if (done[m_owner] || !req[m_owner]) begin
                    m_phase = 2;
                end else if (m_hold == HOLD - 1) begin
                    m_phase = 2;
                    m_abort = 1'b1;
                end else begin
                    m_hold++;
                end
            end
            default: m_phase = 0;
        endcase
        m_edges++;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        for (int i = 0; i < N; i++) bids[i] = 0;
        drive_bids();
        #1;
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_vld", 64'(grant_vld), 64'(0));
        chk("rst_abort", 64'(abort), 64'(0));
        chk("rst_credit", 64'(credit), 64'({N{CW'(CINIT)}}));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_init();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout bench did not finish observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int  order[$];
        int  vld_cnt;
        int  abort_cnt;
        bit  prev_vld;

        #1;
        // Basic bid priority
        do_reset();
        bids[0] = 10;
        bids[1] = 20;
        req = 4'b0011;
        step();
        chk("t1_grant", 64'(grant), 64'(4'b0010));
        chk("t1_cred1", 64'(crd(1)), 64'(5));
        chk("t1_cred0", 64'(crd(0)), 64'(25));
        req = '0;
        repeat (3) step();

        // Equal bids rotate round-robin
        do_reset();
        for (int i = 0; i < N; i++) bids[i] = 5;
        req = 4'b1111;
        prev_vld = 1'b0;
        repeat (15) begin
            done = (m_phase == 1) ? N'(1 << m_owner) : '0;
            step();
            if (grant_vld && !prev_vld) order.push_back(int'(grant_id));
            prev_vld = grant_vld;
        end
        done = '0;
        chk("t2_count", 64'(order.size() >= 5), 64'(1));
        for (int j = 0; j < 5 && j < order.size(); j++) begin
            chk("t2_order", 64'(order[j]), 64'(j % N));
        end
        req = '0;
        repeat (3) step();

        // Insufficient credit waits for refill
        do_reset();
        bids[2] = 30;
        req = 4'b0100;
        repeat (16) step();
        chk("t3_wait_vld", 64'(grant_vld), 64'(0));
        chk("t3_refilled", 64'(crd(2)), 64'(50));
        step();
        chk("t3_grant", 64'(grant), 64'(4'b0100));
        chk("t3_debited", 64'(crd(2)), 64'(20));
        req = '0;
        repeat (3) step();

        // Hold limit forces release with abort
        do_reset();
        bids[3] = 5;
        req = 4'b1000;
        vld_cnt = 0;
        abort_cnt = 0;
        repeat (10) begin
            step();
            vld_cnt += int'(grant_vld);
            abort_cnt += int'(abort);
        end
        chk("t4_hold_cycles", 64'(vld_cnt), 64'(HOLD));
        chk("t4_abort_pulses", 64'(abort_cnt), 64'(1));
        req = '0;
        repeat (3) step();

        // Saturation, then debit coinciding with a refill edge
        do_reset();
        repeat (10 * PER) step();
        chk("t5_saturated", 64'(credit), 64'({N{CW'(CMAX)}}));
        repeat (PER - 1) step();
        bids[0] = 40;
        req = 4'b0001;
        step();
        chk("t5_grant", 64'(grant), 64'(4'b0001));
        chk("t5_debit_refill", 64'(crd(0)), 64'(135));

        // Asynchronous reset in the middle of a grant
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_grant_async", 64'(grant), 64'(0));
        chk("t6_vld_async", 64'(grant_vld), 64'(0));
        chk("t6_credit_async", 64'(credit), 64'({N{CW'(CINIT)}}));

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < N; i++) bids[i] = $urandom_range(0, 40);
        repeat (800) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) bids[$urandom_range(0, N - 1)] = $urandom_range(0, 40);
            done = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : '0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bid_credit_arbiter.md
Name: bid_credit_arbiter

Overview:
Sequential credit/bid arbiter that shares the single master-to-slave bus path between N_MST bus masters.
- Each master holds a credit budget, refilled periodically.
- A requesting master presents a bid; the highest affordable bid wins.
- The winner's credit is debited by its bid, and it holds the bus until it signals done or a hold limit expires.
- Output grant vector drives the existing address-decode/mux block; this block owns all arbitration state.

Parameters:
N_MST, 4, number of requesting masters (2..8)
BID_W, 8, bid width
CRED_W, 10, credit counter width
CRED_INIT, 25, credit loaded at reset
REFILL_AMT, 25, credit added per refill event
REFILL_PERIOD, 16, cycles between refill events
CRED_MAX, 150, credit saturation ceiling (must be < 2^CRED_W)
MAX_HOLD, 8, max cycles a grant is held before forced release

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  N_MST  per-master request level
bid  in  N_MST*BID_W  per-master bid, master i at bits [i*BID_W +: BID_W]
done  in  N_MST  per-master transfer-complete pulse
grant  out  N_MST  one-hot grant, registered
grant_id  out  $clog2(N_MST)  index of granted master, valid while grant_vld
grant_vld  out  1  a grant is active
abort  out  1  one-cycle pulse on forced release at MAX_HOLD
credit  out  N_MST*CRED_W  current credit per master, for observability

Behaviour:
- Reset (async assert, sync release): grant=0, grant_id=0, grant_vld=0, abort=0, all credits=CRED_INIT, refill counter=0, rr_ptr=0, hold counter=0, state=IDLE.
- Eligibility: elig[i] = req[i] && bid[i]!=0 && credit[i] >= bid[i].
- FSM states and transitions:
  - IDLE: if any elig, select winner and go to GRANT. Otherwise stay in IDLE.
    - Winner = max bid among eligible.
    - Tie: first eligible index at or after rr_ptr, wrapping modulo N_MST.
  - GRANT:
    - On entry (same edge): grant[w]=1, grant_id=w, grant_vld=1, credit[w] -= bid[w] (bid sampled at the decision cycle), rr_ptr=(w+1) mod N_MST, hold=0.
    - Each cycle hold++.
    - Exit to GAP on done[w], or on req[w]=0 (treated as done), or when hold==MAX_HOLD-1. In the MAX_HOLD case, abort pulses 1 cycle together with the grant drop.
  - GAP: 1 dead cycle, all grants 0. Then go to IDLE. This guarantees break-before-make on the slave sel lines.
- Latency:
  - Eligible req in IDLE at cycle t -> grant high at t+1.
  - done at t -> grant low at t+1.
  - Earliest next grant is t+3.
- Refill:
  - The free-running counter fires every REFILL_PERIOD cycles.
  - On a fire, each credit becomes min(credit + REFILL_AMT, CRED_MAX).
- Simultaneous debit and refill on the same master: result = min(credit - bid + REFILL_AMT, CRED_MAX), applied in one update with no lost event.
- Credit never underflows, because eligibility guarantees bid <= credit. Credit arithmetic is done at CRED_W+1 bits before saturation.
- done from a non-granted master is ignored.
- bid and req changes during GRANT do not affect the current grant.
- A requester with insufficient credit waits until refill raises its credit. There is no partial grant.
- Reset asserted mid-GRANT: grant drops immediately (async), and credits return to CRED_INIT.

Optional Feature:
BID_ARB_AGING_EN.
- Defined:
  - A per-master 4-bit age counter increments each cycle the master has req=1 and is not granted; it saturates at 15.
  - An eligible master with age==15 beats any bid. Ties among aged masters are broken by rr_ptr.
  - Age clears on grant or when req=0.
- Undefined: no age logic; pure bid priority as described above.

Decomposition:
- Package bid_arb_pkg holds:
  - the state enum typedef (IDLE, GRANT, GAP)
  - credit/bid width localparams
  - the default REFILL_AMT/CRED_MAX constants
- Sub-module bid_arb_pick: combinational winner select (max bid with round-robin tie-break; aging override when enabled). The top module holds the FSM, credits, refill and hold counters.

Test Plan:
- Reset, then req=4'b0011, bids 10/20 -> m1 granted at t+1, credit[1]=5, credit[0]=25.
- Tie: req=4'b1111, all bids 5, rr_ptr=0, each done after 1 cycle -> grant order m0, m1, m2, m3, m0, with a GAP cycle between grants.
- Starvation by credit: m2 bid 30 with credit 25 -> no grant until the refill at cycle 16 (credit 50) -> grant at cycle 17, credit 20.
- Hold limit: m3 granted, done never asserted -> grant drops after 8 cycles, abort pulses 1 cycle, FSM passes through GAP.
- Saturation and simultaneous debit/refill: idle for 10 periods -> credit stays at 150. Then a grant with bid 40 lands on a refill edge -> credit=135.
- Reset mid-grant: rst_n low during GRANT -> grant=0 immediately with no clock edge, and credits=25.
